// File: rtl/qspline_mul_pipe_if.sv
// Sample/result bundle for qspline_mul_pipe: clock enable, operand pair with valid,
// and the scaled result with its valid and overflow flag.
interface qspline_mul_pipe_if #(
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 16,
   parameter int dout_WIDTH = 32
);
   logic                         ce;
   logic                         in_valid;
   logic signed [din0_WIDTH-1:0] din0;
   logic signed [din1_WIDTH-1:0] din1;
   logic                         out_valid;
   logic signed [dout_WIDTH-1:0] dout;
   logic                         ovf;

   modport master (
      output ce, in_valid, din0, din1,
      input  out_valid, dout, ovf
   );

   modport slave (
      input  ce, in_valid, din0, din1,
      output out_valid, dout, ovf
   );
endinterface

// File: rtl/qspline_mul_pipe.sv
// Pipelined signed multiplier with round-half-up rescaling and narrowing to dout_WIDTH.
// Out-of-range results saturate when QSPLINE_MUL_SAT_EN is defined, otherwise they wrap.
module qspline_mul_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 16,
   parameter int dout_WIDTH = 32,
   parameter int FRAC_SHIFT = 0
) (
   input logic               clk,
   input logic               reset,
   qspline_mul_pipe_if.slave bus
);
   localparam int W     = din0_WIDTH + din1_WIDTH;
   localparam int NPIPE = (NUM_STAGE >= 3) ? NUM_STAGE - 2 : 1;
   localparam logic [W:0]        ONE = (W+1)'(1);
   localparam logic signed [W:0] RND = (ONE << FRAC_SHIFT) >> 1;

   logic signed [din0_WIDTH-1:0] a_mul;
   logic signed [din1_WIDTH-1:0] b_mul;
   logic signed [W-1:0]          a_ext;
   logic signed [W-1:0]          b_ext;
   logic signed [W-1:0]          prod;
   logic signed [W-1:0]          p_round;

   logic signed [W:0]             p_ext;
   logic signed [W:0]             r_full;
   logic [W-dout_WIDTH+1:0]       hi_bits;
   logic                          in_range;
   logic signed [dout_WIDTH-1:0]  dout_next;

   logic [NUM_STAGE-1:0]          valid_reg;
   logic signed [dout_WIDTH-1:0]  dout_reg;
   logic                          ovf_reg;

   generate
      if (NUM_STAGE >= 2) begin : g_in_reg
         logic signed [din0_WIDTH-1:0] a_reg;
         logic signed [din1_WIDTH-1:0] b_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               a_reg <= '0;
               b_reg <= '0;
            end else if (bus.ce) begin
               a_reg <= bus.din0;
               b_reg <= bus.din1;
            end
         end

         assign a_mul = a_reg;
         assign b_mul = b_reg;
      end else begin : g_in_comb
         assign a_mul = bus.din0;
         assign b_mul = bus.din1;
      end
   endgenerate

   // Operands are sign-extended to the full product width, so the W-bit product is exact.
   assign a_ext = {{(W-din0_WIDTH){a_mul[din0_WIDTH-1]}}, a_mul};
   assign b_ext = {{(W-din1_WIDTH){b_mul[din1_WIDTH-1]}}, b_mul};
   assign prod  = a_ext * b_ext;

   generate
      if (NUM_STAGE >= 3) begin : g_p_pipe
         logic signed [W-1:0] p_reg [NPIPE];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NPIPE; i++) p_reg[i] <= '0;
            end else if (bus.ce) begin
               p_reg[0] <= prod;
               for (int i = 1; i < NPIPE; i++) p_reg[i] <= p_reg[i-1];
            end
         end

         assign p_round = p_reg[NPIPE-1];
      end else begin : g_p_comb
         assign p_round = prod;
      end
   endgenerate

`ifdef QSPLINE_MUL_SAT_EN
   localparam logic signed [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic signed [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
`endif

   // One guard bit above the product keeps the rounding add from overflowing.
   always_comb begin
      p_ext     = {p_round[W-1], p_round};
      r_full    = (p_ext + RND) >>> FRAC_SHIFT;
      hi_bits   = r_full[W:dout_WIDTH-1];
      in_range  = (&hi_bits) | ~(|hi_bits);
`ifdef QSPLINE_MUL_SAT_EN
      dout_next = in_range ? r_full[dout_WIDTH-1:0] : (r_full[W] ? DOUT_MIN : DOUT_MAX);
`else
      dout_next = r_full[dout_WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= '0;
         dout_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else if (bus.ce) begin
         valid_reg[0] <= bus.in_valid;
         for (int i = 1; i < NUM_STAGE; i++) valid_reg[i] <= valid_reg[i-1];
         dout_reg <= dout_next;
         ovf_reg  <= ~in_range;
      end
   end

   assign bus.out_valid = valid_reg[NUM_STAGE-1];
   assign bus.dout      = dout_reg;
   assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_qspline_mul_pipe.sv
// Bench for qspline_mul_pipe: five configurations share one stimulus stream and are
// compared every cycle against an arithmetic model of the enabled-edge sample history.
module tb_qspline_mul_pipe;
   localparam int NDUT = 5;
   localparam int NS_C [NDUT] = '{3, 2, 4, 1, 6};
   localparam int FS_C [NDUT] = '{0, 15, 0, 1, 7};
   localparam int DW_C [NDUT] = '{32, 16, 32, 18, 12};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              ce;
   logic              in_valid;
   logic signed [15:0] din0;
   logic signed [15:0] din1;

   logic   got_valid [NDUT];
   longint got_dout  [NDUT];
   logic   got_ovf   [NDUT];

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         qspline_mul_pipe_if #(
            .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(DW_C[gi])
         ) bus ();

         assign bus.ce       = ce;
         assign bus.in_valid = in_valid;
         assign bus.din0     = din0;
         assign bus.din1     = din1;

         qspline_mul_pipe #(
            .ID(gi + 1), .NUM_STAGE(NS_C[gi]), .din0_WIDTH(16), .din1_WIDTH(16),
            .dout_WIDTH(DW_C[gi]), .FRAC_SHIFT(FS_C[gi])
         ) u_dut (
            .clk(clk), .reset(rst), .bus(bus)
         );

         assign got_valid[gi] = bus.out_valid;
         assign got_dout[gi]  = longint'(bus.dout);
         assign got_ovf[gi]   = bus.ovf;
      end
   endgenerate

   typedef struct {
      bit     v;
      longint a;
      longint b;
   } stim_t;

   stim_t stim_q[$];
   int    n_en = 0;
   int    n_tests = 0;
   int    n_fail = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model(input longint a, input longint b, input int fs, input int dw,
                                 output longint d, output longint o);
      longint p, r, span, mx, mn;
      p = a * b;
      r = p;
      if (fs > 0) r = (p + (longint'(1) << (fs - 1))) >>> fs;
      span = longint'(1) << dw;
      mx   = span / 2 - 1;
      mn   = -(span / 2);
      if (r > mx || r < mn) begin
         o = 1;
`ifdef QSPLINE_MUL_SAT_EN
         d = (r > mx) ? mx : mn;
`else
         d = r & (span - 1);
         if (d > mx) d = d - span;
`endif
      end else begin
         o = 0;
         d = r;
      end
   endfunction

   // One clock: drive inputs, advance the model on the edge, compare every instance.
   task automatic step(input bit r, input bit c, input bit v, input longint a, input longint b);
      stim_t  e;
      longint ed, eo;
      rst      = r;
      ce       = c;
      in_valid = v;
      din0     = 16'(a);
      din1     = 16'(b);
      @(posedge clk);
      #1;
      if (r) begin
         stim_q.delete();
         n_en = 0;
      end else if (c) begin
         stim_q.push_back('{v, a, b});
         n_en++;
      end
      for (int i = 0; i < NDUT; i++) begin
         if (n_en >= NS_C[i]) begin
            e = stim_q[n_en - NS_C[i]];
            check($sformatf("d%0d_valid", i), got_valid[i], e.v);
            if (e.v) begin
               model(e.a, e.b, FS_C[i], DW_C[i], ed, eo);
               check($sformatf("d%0d_dout(%0d*%0d)", i, e.a, e.b), got_dout[i], ed);
               check($sformatf("d%0d_ovf(%0d*%0d)", i, e.a, e.b), got_ovf[i], eo);
            end
         end else begin
            check($sformatf("d%0d_valid_empty", i), got_valid[i], 0);
            if (n_en == 0) begin
               check($sformatf("d%0d_dout_reset", i), got_dout[i], 0);
               check($sformatf("d%0d_ovf_reset", i), got_ovf[i], 0);
            end
         end
      end
   endtask

   function automatic longint rand_op();
      int s;
      s = $urandom_range(0, 7);
      case (s)
         0:       return -32768;
         1:       return 32767;
         default: return longint'($signed(16'($urandom)));
      endcase
   endfunction

   int  next_out;
   int  seen;
   bit  prev_v;

   initial begin
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);

      // Exact full-scale product and 16-bit overflow.
      step(0, 1, 1, -32768, -32768);
      step(0, 1, 0, 0, 0);
`ifdef QSPLINE_MUL_SAT_EN
      check("d1_overflow_dout", got_dout[1], 32767);
`else
      check("d1_overflow_dout", got_dout[1], -32768);
`endif
      check("d1_overflow_ovf", got_ovf[1], 1);
      step(0, 1, 0, 0, 0);
      check("d0_exact_valid", got_valid[0], 1);
      check("d0_exact_dout", got_dout[0], 1073741824);
      check("d0_exact_ovf", got_ovf[0], 0);

      // Round-half-up with one fractional bit.
      step(0, 1, 1, 3, 1);
      check("d3_round_3", got_dout[3], 2);
      check("d3_round_3_ovf", got_ovf[3], 0);
      step(0, 1, 1, -3, 1);
      check("d3_round_m3", got_dout[3], -1);
      check("d3_round_m3_ovf", got_ovf[3], 0);
      step(0, 1, 1, 2, 1);
      check("d3_round_2", got_dout[3], 1);
      check("d3_round_2_ovf", got_ovf[3], 0);

      // Stream 1..8 with a five-cycle clock-enable stall in the middle.
      for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
      next_out = 1;
      for (int k = 1; k <= 8; k++) begin
         if (k == 5) for (int s = 0; s < 5; s++) step(0, 0, 1, 99, 99);
         step(0, 1, 1, k, 1);
         if (got_valid[2]) begin
            check("d2_stream_order", got_dout[2], next_out);
            next_out++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0, 0);
         if (got_valid[2]) begin
            check("d2_stream_order", got_dout[2], next_out);
            next_out++;
         end
      end
      check("d2_stream_count", next_out, 9);

      // Reset with ce low discards three samples in flight.
      for (int k = 1; k <= 3; k++) step(0, 1, 1, 1000 + k, 7);
      step(1, 0, 0, 0, 0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 0, 0, 0);
         for (int i = 0; i < NDUT; i++) if (got_valid[i]) seen++;
      end
      check("reset_flush_valids", seen, 0);

      // Alternating valid with random operands.
      prev_v = 0;
      for (int k = 0; k < 40; k++) begin
         step(0, 1, (k % 2) == 0, rand_op(), rand_op());
         check("d3_gap_pattern", got_valid[3], (k % 2) == 0);
         prev_v = (k % 2) == 0;
      end

      // Random enable, valid, operands and occasional reset.
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
              1'($urandom_range(0, 1)), rand_op(), rand_op());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
